// File: rtl/srt_pkg.sv
// srt_pkg: shared defaults, lane packing order and count-width helper for the result collector
package srt_pkg;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int LANE_R0 = 0;
  localparam int LANE_R1 = 1;
  localparam int LANE_R2 = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/srt_fwft_fifo.sv
// srt_fwft_fifo: first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop
module srt_fwft_fifo
  import srt_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage write; contents need no reset since empty masks the head
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/srt_result_collector.sv
// srt_result_collector: tracks array issues, captures aligned results into a FWFT FIFO and streams them out; SRT_COLLECT_TLAST_EN enables frame tlast
module srt_result_collector
  import srt_pkg::*;
#(
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int LATENCY = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OUT_WIDTH-1:0]   result0,
  input  logic [OUT_WIDTH-1:0]   result1,
  input  logic [OUT_WIDTH-1:0]   result2,
  output logic [3*OUT_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   overflow
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be 1..15");
  end
  if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame
    $error("FRAME_LEN must be 1..65535");
  end
  logic [LATENCY-1:0] vld_sr;
  logic [3:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW+3:0] occ;
  logic [3*OUT_WIDTH-1:0] din;
  logic cap, pop, full, empty;
  assign cap = vld_sr[LATENCY-1];
  assign pop = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = ~empty;
  assign occ = (CW+4)'(fifo_count) + (CW+4)'(inflight);
  assign in_ready = occ < (CW+4)'(FIFO_DEPTH);
  // pack the three lanes into one FIFO word
  always_comb begin
    din = '0;
    din[LANE_R0*OUT_WIDTH +: OUT_WIDTH] = result0;
    din[LANE_R1*OUT_WIDTH +: OUT_WIDTH] = result1;
    din[LANE_R2*OUT_WIDTH +: OUT_WIDTH] = result2;
  end
  // every issue is tracked, even unaccepted ones, since the array cannot stall
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_sr <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= LATENCY'({vld_sr, in_valid});
      inflight <= inflight + 4'(in_valid) - 4'(cap);
    end
  end
  // sticky drop flag: capture into a full FIFO with no pop to make room
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) overflow <= 1'b0;
    else if (cap & full & ~pop) overflow <= 1'b1;
  end
  srt_fwft_fifo #(.WIDTH(3*OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (cap),
    .pop     (pop),
    .din     (din),
    .dout    (m_axis_tdata),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );
`ifdef SRT_COLLECT_TLAST_EN
  logic [15:0] beat;
  assign m_axis_tlast = m_axis_tvalid & (beat == 16'(FRAME_LEN - 1));
  // count popped beats, wrapping at the frame boundary
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) beat <= '0;
    else if (pop) beat <= (beat == 16'(FRAME_LEN - 1)) ? '0 : beat + 16'd1;
  end
`else
  assign m_axis_tlast = 1'b0;
`endif
endmodule
